freq_meas_sequencer: RTL and testbench
======================================

// Module: freq_meas_sequencer
// PURPOSE
//  Sequences low_freq_counter_bcd: issues start pulses, waits for done, latches BCD result and status.
//  Supports one-shot and continuous (auto-repeat with gap) modes, plus a display hold.
//  Sits between user controls (buttons/switches) and the counter; outputs feed the 7-seg mux.
// PARAMETERS
//  CLK_FREQ     100_000_000  clock frequency, Hz
//  INTERVAL_MS  250          idle gap between measurements in continuous mode, ms
//  TIMEOUT_MS   2500         max wait for counter done before abort, ms (FREQ_SEQ_TIMEOUT_EN only)
// PORTS
//  i_clk             in   1  system clock
//  i_rst_n           in   1  asynchronous reset, active-low
//  i_run             in   1  level: continuous measurement enable
//  i_single          in   1  1-cycle pulse: request one measurement
//  i_hold            in   1  level: freeze display registers
//  o_meas_start      out  1  1-cycle start pulse to counter i_start
//  o_meas_abort      out  1  1-cycle sync reset pulse to counter (timeout recovery)
//  i_meas_ready      in   1  counter idle/ready
//  i_meas_done       in   1  counter done, 1-cycle pulse; result valid in that cycle
//  i_meas_bcd3..0    in   4  counter BCD digits (each its own port)
//  i_meas_dp         in   4  counter one-hot decimal point
//  i_meas_overflow   in   1  counter frequency overflow
//  i_meas_underflow  in   1  counter frequency underflow
//  o_disp_bcd3..0    out  4  latched digits (each its own port)
//  o_disp_dp         out  4  latched decimal point
//  o_status          out  2  status_t: NONE=0, OK=1, RANGE=2 (ovf/unf), TMO=3
//  o_valid           out  1  1-cycle pulse on each new OK result written to display
//  o_busy            out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, timers cleared; abort/reset mid-operation returns to IDLE at once.
//  States: IDLE, ARM, START, WAIT_DONE, LATCH, GAP, ABORT.
//  IDLE: i_single or i_run -> ARM; if both, single occurs once, then continues as run.
//  ARM: wait i_meas_ready=1 -> START. START: o_meas_start=1 for exactly one cycle -> WAIT_DONE.
//  WAIT_DONE: on i_meas_done -> LATCH, sampling bcd/dp/ovf/unf that same cycle.
//  LATCH (1 cycle): ovf|unf -> o_status=RANGE, display keeps last OK value, no o_valid;
//    else o_status=OK and display <= sampled data unless i_hold, o_valid=1 only if written.
//    Then i_run -> GAP else IDLE. Status always updates, even under hold.
//  GAP: count INTERVAL_MS*CLK_FREQ/1000 cycles; at terminal count i_run -> ARM else IDLE;
//    i_single during GAP cuts the gap short -> ARM next cycle.
//  i_run drop mid-measurement: current measurement completes and latches, then IDLE.
//  i_single while busy (not IDLE/GAP): ignored, not queued.
//  Latency: start pulse 1 cycle after ARM sees ready; o_valid 1 cycle after i_meas_done.
//  Timer widths: $clog2(max cycle count + 1); counts are computed as integer constants at elaboration.
// CONFIGURATION
//  FREQ_SEQ_TIMEOUT_EN defined: WAIT_DONE timer counts TIMEOUT_MS*CLK_FREQ/1000 cycles;
//    on expiry -> ABORT: o_meas_abort=1 one cycle, o_status=TMO, display unchanged,
//    then GAP if i_run else IDLE. A done arriving in the same cycle as expiry wins (-> LATCH).
//  Undefined: no timeout; WAIT_DONE waits indefinitely; o_meas_abort tied 0; TMO never produced.
// STRUCTURE
//  freq_seq_pkg: state_t enum, status_t enum, ms_to_cycles() constant function.
//  Sub-module freq_seq_timer: loadable down-counter (i_load, i_count, o_zero), reused for GAP
//    and the timeout.
// TESTING (bench: CLK_FREQ=10_000 so 1 ms = 10 cycles, INTERVAL_MS=2, TIMEOUT_MS=5; behavioural counter model)
//  1. i_single, model done after 30 cycles with 1.000 dp=8 -> one start pulse, disp 1,0,0,0 dp=8,
//     status OK, one o_valid, then IDLE, busy=0.
//  2. i_run=1, model done in 15 cycles each -> start pulses >=20 cycles apart (GAP), o_valid per result.
//  3. Good 0123 dp=1, then ovf=1 -> status RANGE, display stays 0123 dp=1, no o_valid.
//  4. i_hold=1 during OK result 0456 -> display unchanged, status OK, no o_valid; release -> next result shown.
//  5. (FREQ_SEQ_TIMEOUT_EN) no done for 50 cycles -> o_meas_abort pulse at cycle 50, status TMO;
//     without macro -> stays WAIT_DONE, abort never asserted.
//  6. i_rst_n low in WAIT_DONE -> all outputs 0 immediately; i_run drop mid-measure -> latch, then IDLE.

Source files
------------

// File: rtl/freq_seq_pkg.sv
// Shared types and helpers for the frequency-measurement sequencer.
package freq_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_START,
        S_WAIT_DONE,
        S_LATCH,
        S_GAP,
        S_ABORT
    } state_t;

    typedef enum logic [1:0] {
        ST_NONE  = 2'd0,
        ST_OK    = 2'd1,
        ST_RANGE = 2'd2,
        ST_TMO   = 2'd3
    } status_t;

    // 64-bit intermediate: ms * Hz overflows 32 bits at realistic clock rates.
    function automatic int ms_to_cycles(input int ms, input int clk_freq);
        longint c;
        c = longint'(ms) * longint'(clk_freq) / 64'sd1000;
        return int'(c);
    endfunction

endpackage

// File: rtl/freq_seq_timer.sv
// Loadable down-counter; o_zero is high while the count rests at zero.
module freq_seq_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_count,
    input  logic [W-1:0] i_value,
    output logic         o_zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_load) begin
            cnt <= i_value;
        end else if (i_count && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign o_zero = (cnt == '0);

endmodule

// File: rtl/freq_meas_sequencer.sv
// Sequences a BCD frequency counter: start, wait done, latch result/status, optional repeat.
// Optional feature macro: FREQ_SEQ_TIMEOUT_EN (abort the counter if done never arrives).
module freq_meas_sequencer
    import freq_seq_pkg::*;
#(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int INTERVAL_MS = 250,
    parameter int TIMEOUT_MS  = 2500
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_run,
    input  logic       i_single,
    input  logic       i_hold,
    output logic       o_meas_start,
    output logic       o_meas_abort,
    input  logic       i_meas_ready,
    input  logic       i_meas_done,
    input  logic [3:0] i_meas_bcd3,
    input  logic [3:0] i_meas_bcd2,
    input  logic [3:0] i_meas_bcd1,
    input  logic [3:0] i_meas_bcd0,
    input  logic [3:0] i_meas_dp,
    input  logic       i_meas_overflow,
    input  logic       i_meas_underflow,
    output logic [3:0] o_disp_bcd3,
    output logic [3:0] o_disp_bcd2,
    output logic [3:0] o_disp_bcd1,
    output logic [3:0] o_disp_bcd0,
    output logic [3:0] o_disp_dp,
    output logic [1:0] o_status,
    output logic       o_valid,
    output logic       o_busy
);

    localparam int GAP_CYC = ms_to_cycles(INTERVAL_MS, CLK_FREQ);
`ifdef FREQ_SEQ_TIMEOUT_EN
    localparam int TMO_CYC = ms_to_cycles(TIMEOUT_MS, CLK_FREQ);
    localparam int MAX_CYC = (GAP_CYC > TMO_CYC) ? GAP_CYC : TMO_CYC;
`else
    localparam int MAX_CYC = GAP_CYC;
`endif
    localparam int TW = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    // Load N-1 so that the GAP/WAIT state lasts exactly N cycles before o_zero.
    localparam logic [TW-1:0] GAP_LD = TW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
`ifdef FREQ_SEQ_TIMEOUT_EN
    localparam logic [TW-1:0] TMO_LD = TW'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);
`endif

    state_t        state;
    status_t       status;
    logic          tmr_load;
    logic          tmr_count;
    logic [TW-1:0] tmr_value;
    logic          tmr_zero;

    // One timer serves both intervals: LATCH/ABORT preload the gap, START preloads the timeout.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_count = 1'b0;
        tmr_value = GAP_LD;
        case (state)
`ifdef FREQ_SEQ_TIMEOUT_EN
            S_START: begin
                tmr_load  = 1'b1;
                tmr_value = TMO_LD;
            end
`endif
            S_LATCH, S_ABORT:  tmr_load  = 1'b1;
            S_WAIT_DONE, S_GAP: tmr_count = 1'b1;
            default: ;
        endcase
    end

    freq_seq_timer #(.W(TW)) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (tmr_load),
        .i_count (tmr_count),
        .i_value (tmr_value),
        .o_zero  (tmr_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            status       <= ST_NONE;
            o_meas_start <= 1'b0;
            o_meas_abort <= 1'b0;
            o_valid      <= 1'b0;
            o_disp_bcd3  <= 4'd0;
            o_disp_bcd2  <= 4'd0;
            o_disp_bcd1  <= 4'd0;
            o_disp_bcd0  <= 4'd0;
            o_disp_dp    <= 4'd0;
        end else begin
            o_meas_start <= 1'b0;
            o_meas_abort <= 1'b0;
            o_valid      <= 1'b0;
            case (state)
                S_IDLE: if (i_single || i_run) state <= S_ARM;
                S_ARM: begin
                    if (i_meas_ready) begin
                        state        <= S_START;
                        o_meas_start <= 1'b1;
                    end
                end
                S_START: state <= S_WAIT_DONE;
                S_WAIT_DONE: begin
                    // Result is committed on the done cycle so it is visible during LATCH.
                    if (i_meas_done) begin
                        state <= S_LATCH;
                        if (i_meas_overflow || i_meas_underflow) begin
                            status <= ST_RANGE;
                        end else begin
                            status <= ST_OK;
                            if (!i_hold) begin
                                o_disp_bcd3 <= i_meas_bcd3;
                                o_disp_bcd2 <= i_meas_bcd2;
                                o_disp_bcd1 <= i_meas_bcd1;
                                o_disp_bcd0 <= i_meas_bcd0;
                                o_disp_dp   <= i_meas_dp;
                                o_valid     <= 1'b1;
                            end
                        end
                    end
`ifdef FREQ_SEQ_TIMEOUT_EN
                    else if (tmr_zero) begin
                        state        <= S_ABORT;
                        status       <= ST_TMO;
                        o_meas_abort <= 1'b1;
                    end
`endif
                end
                S_LATCH, S_ABORT: state <= i_run ? S_GAP : S_IDLE;
                S_GAP: begin
                    if (i_single)      state <= S_ARM;
                    else if (tmr_zero) state <= i_run ? S_ARM : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_status = status;
    assign o_busy   = (state != S_IDLE);

endmodule

// File: tb/tb_freq_meas_sequencer.sv
// Directed bench with a behavioural counter model and a result scoreboard.
module tb_freq_meas_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0, single = 1'b0, hold = 1'b0;
    logic        meas_ready = 1'b1, meas_done = 1'b0;
    logic [15:0] m_word = 16'h0;
    logic [3:0]  m_dp = 4'h0;
    logic        m_ovf = 1'b0, m_unf = 1'b0;
    logic        meas_start, meas_abort, valid, busy;
    logic [3:0]  d3, d2, d1, d0, ddp;
    logic [1:0]  status;
    logic [15:0] disp_w;

    assign disp_w = {d3, d2, d1, d0};

    always #5 clk = ~clk;

    freq_meas_sequencer #(.CLK_FREQ(10_000), .INTERVAL_MS(2), .TIMEOUT_MS(5)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_single(single), .i_hold(hold),
        .o_meas_start(meas_start), .o_meas_abort(meas_abort),
        .i_meas_ready(meas_ready), .i_meas_done(meas_done),
        .i_meas_bcd3(m_word[15:12]), .i_meas_bcd2(m_word[11:8]),
        .i_meas_bcd1(m_word[7:4]), .i_meas_bcd0(m_word[3:0]),
        .i_meas_dp(m_dp), .i_meas_overflow(m_ovf), .i_meas_underflow(m_unf),
        .o_disp_bcd3(d3), .o_disp_bcd2(d2), .o_disp_bcd1(d1), .o_disp_bcd0(d0),
        .o_disp_dp(ddp), .o_status(status), .o_valid(valid), .o_busy(busy)
    );

    typedef struct {
        logic [15:0] disp;
        logic [3:0]  dp;
        logic [1:0]  status;
        logic        valid;
    } exp_t;
    exp_t sb[$];

    int nchk = 0, nerr = 0;
    int n_start = 0, n_valid = 0, n_abort = 0, cyc = 0;
    int start_cyc = 0, abort_cyc = 0, last_start = -1, min_sp = 1000000;
    int model_delay = 30, left = 0;
    bit model_mute = 0, active = 0, prev_done = 0;
    logic [15:0] ref_disp = 16'h0;
    logic [3:0]  ref_dp = 4'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_single();
        @(negedge clk); single = 1'b1;
        @(negedge clk); single = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        int n = 0;
        while (busy && n < maxc) begin @(negedge clk); n++; end
        chk(tag, busy, 0);
        @(negedge clk);
    endtask

    // Counter model + scoreboard: expectation pushed when done is issued, checked one cycle later.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                active = 0; meas_done = 0; meas_ready = 1; prev_done = 0;
            end else begin
                if (prev_done) begin
                    if (sb.size() == 0) chk("sb_empty", 1, 0);
                    else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("sb_disp", disp_w, e.disp);
                        chk("sb_dp", ddp, e.dp);
                        chk("sb_status", status, e.status);
                        chk("sb_valid", valid, e.valid);
                    end
                end
                meas_done = 0;
                if (valid) n_valid++;
                if (meas_abort) begin
                    n_abort++; abort_cyc = cyc; active = 0; meas_ready = 1;
                end
                if (meas_start) begin
                    n_start++; start_cyc = cyc;
                    if (last_start >= 0 && cyc - last_start < min_sp) min_sp = cyc - last_start;
                    last_start = cyc;
                    active = 1; meas_ready = 0; left = model_delay;
                end else if (active && !model_mute) begin
                    left--;
                    if (left <= 0) begin
                        exp_t e;
                        active = 0; meas_ready = 1; meas_done = 1;
                        if (m_ovf || m_unf) begin
                            e.status = 2'd2; e.valid = 1'b0;
                        end else begin
                            e.status = 2'd1;
                            e.valid  = !hold;
                            if (!hold) begin ref_disp = m_word; ref_dp = m_dp; end
                        end
                        e.disp = ref_disp; e.dp = ref_dp;
                        sb.push_back(e);
                    end
                end
                prev_done = meas_done;
            end
        end
    end

    initial begin
        int s0, v0, a0, n;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_start", meas_start, 0);
        chk("rst_abort", meas_abort, 0);
        chk("rst_valid", valid, 0);
        chk("rst_status", status, 0);
        chk("rst_disp", {disp_w, ddp}, 20'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // 1: single shot, second single while busy must be ignored
        m_word = 16'h1000; m_dp = 4'b1000; model_delay = 30;
        s0 = n_start; v0 = n_valid;
        pulse_single();
        repeat (5) @(negedge clk);
        pulse_single();
        wait_idle(200, "t1_idle");
        chk("t1_starts", n_start - s0, 1);
        chk("t1_valids", n_valid - v0, 1);
        chk("t1_disp", disp_w, 16'h1000);
        chk("t1_dp", ddp, 4'b1000);
        chk("t1_status", status, 1);

        // 2: continuous mode with gap between starts
        m_word = 16'h2345; m_dp = 4'b0100; model_delay = 15;
        last_start = -1; min_sp = 1000000; v0 = n_valid;
        @(negedge clk); run = 1'b1;
        n = 0;
        while (n_valid < v0 + 3 && n < 400) begin @(negedge clk); n++; end
        chk("t2_results", (n_valid - v0 >= 3), 1);
        chk("t2_spacing", (min_sp >= 20), 1);
        run = 1'b0;
        wait_idle(200, "t2_idle");
        chk("t2_disp", disp_w, 16'h2345);

        // 3: good result, then overflow and underflow keep display
        m_word = 16'h0123; m_dp = 4'b0001; model_delay = 10;
        pulse_single(); wait_idle(100, "t3a_idle");
        chk("t3a_disp", disp_w, 16'h0123);
        m_word = 16'h9999; m_dp = 4'b1111; m_ovf = 1'b1; v0 = n_valid;
        pulse_single(); wait_idle(100, "t3b_idle");
        chk("t3b_status", status, 2);
        chk("t3b_disp", disp_w, 16'h0123);
        chk("t3b_dp", ddp, 4'b0001);
        chk("t3b_valid", n_valid - v0, 0);
        m_ovf = 1'b0; m_unf = 1'b1;
        pulse_single(); wait_idle(100, "t3c_idle");
        chk("t3c_status", status, 2);
        chk("t3c_disp", disp_w, 16'h0123);
        m_unf = 1'b0;

        // 4: hold freezes display but status updates
        hold = 1'b1; m_word = 16'h0456; m_dp = 4'b0010; v0 = n_valid;
        pulse_single(); wait_idle(100, "t4a_idle");
        chk("t4a_disp", disp_w, 16'h0123);
        chk("t4a_status", status, 1);
        chk("t4a_valid", n_valid - v0, 0);
        hold = 1'b0; v0 = n_valid;
        pulse_single(); wait_idle(100, "t4b_idle");
        chk("t4b_disp", disp_w, 16'h0456);
        chk("t4b_dp", ddp, 4'b0010);
        chk("t4b_valid", n_valid - v0, 1);

        // 5: counter never answers
        model_mute = 1; a0 = n_abort;
        pulse_single();
`ifdef FREQ_SEQ_TIMEOUT_EN
        n = 0;
        while (n_abort == a0 && n < 100) begin @(negedge clk); n++; end
        chk("t5_abort_cnt", n_abort - a0, 1);
        chk("t5_abort_time", (abort_cyc - start_cyc >= 49 && abort_cyc - start_cyc <= 52), 1);
        chk("t5_status", status, 3);
        chk("t5_disp", disp_w, 16'h0456);
        wait_idle(20, "t5_idle");
        pulse_single();
        repeat (10) @(negedge clk);
`else
        repeat (80) @(negedge clk);
        chk("t5_abort_cnt", n_abort - a0, 0);
        chk("t5_abort_pin", meas_abort, 0);
        chk("t5_status", status, 1);
`endif
        // 6: async reset while waiting for done
        chk("t6_busy_pre", busy, 1);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_status", status, 0);
        chk("t6_disp", {disp_w, ddp}, 20'h0);
        chk("t6_pulses", {meas_start, meas_abort, valid}, 0);
        model_mute = 0; ref_disp = 16'h0; ref_dp = 4'h0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // 6b: run dropped mid-measurement still latches, then idles
        m_word = 16'h0789; m_dp = 4'b0001; model_delay = 15;
        s0 = n_start; v0 = n_valid;
        @(negedge clk); run = 1'b1;
        n = 0;
        while (n_start == s0 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk); run = 1'b0;
        wait_idle(100, "t6b_idle");
        repeat (30) @(negedge clk);
        chk("t6b_starts", n_start - s0, 1);
        chk("t6b_valids", n_valid - v0, 1);
        chk("t6b_disp", disp_w, 16'h0789);
        chk("t6b_busy", busy, 0);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
